// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, constants and PC helper for the fetch front end
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
    logic                  fault;
  } fetch_entry_t;

  function automatic logic [FETCH_XLEN-1:0] pc_inc(input logic [FETCH_XLEN-1:0] pc);
    return pc + FETCH_XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - request/grant instruction-memory port with in-order responses
interface fetch_if #(
  parameter int XLEN = 32
) ();
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular prefetch queue of fetch entries with synchronous clear
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] occupancy
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push = push && !clear && (count_q != CW'(DEPTH));
    do_pop  = pop && !clear && (count_q != '0);
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (clear) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: the head is only consumed while occupancy is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_entry;
  end

  assign head      = mem_q[rd_q];
  assign occupancy = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - prefetching IF stage with credit-based issue and redirect drop; option FETCH_ALIGN_CHK_EN
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN            = FETCH_XLEN,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  fetch_if.master         imem,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            instr_ready_i
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic            instr_fault_o
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int UW = CW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, fault_pc_q, fault_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  logic            halt_q, halt_d, fault_pend_q, fault_pend_d;
  logic [CW-1:0]   occupancy;
  logic [UW-1:0]   in_use;
  logic            issue, push, pop, clear, misaligned;
  logic [XLEN-1:0] target_pc;
  fetch_entry_t    push_entry, head;

`ifdef FETCH_ALIGN_CHK_EN
  assign misaligned = |redirect_pc_i[1:0];
`else
  assign misaligned = 1'b0;
`endif
  assign target_pc = {redirect_pc_i[XLEN-1:2], 2'b00};

  // Words already granted but not yet returned are counted as occupied slots,
  // so a response that is not being dropped can always be written.
  assign in_use = UW'(occupancy) + UW'(outstanding_q) - UW'(drop_cnt_q);
  assign issue  = !arst && !redirect_i && !halt_q
                  && (outstanding_q < CW'(MAX_OUTSTANDING))
                  && (in_use < UW'(DEPTH));

  assign imem.req  = issue;
  assign imem.addr = fetch_pc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    halt_d        = halt_q;
    fault_pend_d  = 1'b0;
    fault_pc_d    = fault_pc_q;
    clear         = 1'b0;
    push          = 1'b0;
    pop           = instr_valid_o && instr_ready_i;
    push_entry    = '{pc: resp_pc_q, instr: imem.rdata, fault: 1'b0};

    if (issue && imem.gnt) begin
      fetch_pc_d    = pc_inc(fetch_pc_q);
      outstanding_d = outstanding_q + CW'(1);
    end
    if (imem.rvalid) begin
      outstanding_d = outstanding_d - CW'(1);
      if (drop_cnt_q != '0) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end else begin
        push      = 1'b1;
        resp_pc_d = pc_inc(resp_pc_q);
      end
    end
    if (fault_pend_q) begin
      push       = 1'b1;
      push_entry = '{pc: fault_pc_q, instr: NOP_INSTR, fault: 1'b1};
    end

    // Everything still in flight after this cycle belongs to the old stream.
    if (redirect_i) begin
      clear        = 1'b1;
      push         = 1'b0;
      pop          = 1'b0;
      fetch_pc_d   = target_pc;
      resp_pc_d    = target_pc;
      drop_cnt_d   = outstanding_d;
      halt_d       = misaligned;
      fault_pend_d = misaligned;
      fault_pc_d   = redirect_pc_i;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      fault_pc_q    <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      halt_q        <= 1'b0;
      fault_pend_q  <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      fault_pc_q    <= fault_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      halt_q        <= halt_d;
      fault_pend_q  <= fault_pend_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .arst       (arst),
    .clear      (clear),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .occupancy  (occupancy)
  );

  assign instr_valid_o = (occupancy != '0);
  assign instr_o       = instr_valid_o ? head.instr : '0;
  assign pc_o          = instr_valid_o ? head.pc : '0;

`ifdef FETCH_ALIGN_CHK_EN
  assign instr_fault_o = instr_valid_o && head.fault;
`else
  logic unused_fault;
  assign unused_fault = head.fault;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a fixed-latency memory model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        arst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;
  logic        fault_w;
  logic        gnt;
  int          lat;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] grants[$];
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  logic        pop_fault[$];

  fetch_if #(.XLEN(32)) imem_bus ();

  fetch_unit #(
    .XLEN            (32),
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (imem_bus),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_ready_i (instr_ready_i)
`ifdef FETCH_ALIGN_CHK_EN
    ,
    .instr_fault_o (fault_w)
`endif
  );

`ifndef FETCH_ALIGN_CHK_EN
  assign fault_w = 1'b0;
`endif

  assign imem_bus.gnt = gnt;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_pop(input string tag, input int idx, input logic [31:0] exp_pc,
                           input logic [31:0] exp_instr, input logic exp_fault);
    check({tag, "_present"}, 32'(pop_pc.size() > idx), 32'd1);
    if (pop_pc.size() > idx) begin
      check({tag, "_pc"}, pop_pc[idx], exp_pc);
      check({tag, "_instr"}, pop_instr[idx], exp_instr);
      check({tag, "_fault"}, 32'(pop_fault[idx]), 32'(exp_fault));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst          = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    grants.delete();
    pop_pc.delete();
    pop_instr.delete();
    pop_fault.delete();
    arst = 1'b0;
  endtask

  // Memory: response word is address + 0x1000_0000, returned lat cycles after the grant cycle.
  initial begin
    int n;
    n = 0;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = '0;
    forever begin
      @(negedge clk);
      n++;
      imem_bus.rvalid = 1'b0;
      if (arst) begin
        mem_addr_q.delete();
        mem_due_q.delete();
      end else begin
        if (mem_due_q.size() > 0 && mem_due_q[0] == n) begin
          imem_bus.rvalid = 1'b1;
          imem_bus.rdata  = mem_addr_q[0] + 32'h1000_0000;
          void'(mem_addr_q.pop_front());
          void'(mem_due_q.pop_front());
        end
        if (imem_bus.req && imem_bus.gnt) begin
          grants.push_back(imem_bus.addr);
          mem_addr_q.push_back(imem_bus.addr);
          mem_due_q.push_back(n + lat);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!arst && instr_valid_o && instr_ready_i && !redirect_i) begin
        pop_pc.push_back(pc_o);
        pop_instr.push_back(instr_o);
        pop_fault.push_back(fault_w);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    arst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    instr_ready_i = 1'b1; gnt = 1'b1; lat = 1;
    @(negedge clk);
    check("rst_req", 32'(imem_bus.req), 32'd0);
    check("rst_addr", imem_bus.addr, 32'h0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", pc_o, 32'h0);

    // Streaming with 1-cycle memory
    do_reset();
    @(negedge clk);
    check("t1_req0", 32'(imem_bus.req), 32'd1);
    check("t1_addr0", imem_bus.addr, 32'h0);
    check("t1_valid0", 32'(instr_valid_o), 32'd0);
    step(); @(negedge clk);
    check("t1_valid1", 32'(instr_valid_o), 32'd0);
    check("t1_addr1", imem_bus.addr, 32'h4);
    step(); @(negedge clk);
    check("t1_valid2", 32'(instr_valid_o), 32'd1);
    check("t1_pc0", pc_o, 32'h0);
    check("t1_instr0", instr_o, 32'h1000_0000);
    step(); @(negedge clk);
    check("t1_pc1", pc_o, 32'h4);
    step(); @(negedge clk);
    check("t1_pc2", pc_o, 32'h8);

    // Stall fills the queue, then drains in order
    lat = 1; instr_ready_i = 1'b0;
    do_reset();
    repeat (10) step();
    @(negedge clk);
    check("t2_req_low", 32'(imem_bus.req), 32'd0);
    check("t2_grants", 32'(grants.size()), 32'd4);
    check("t2_pending", 32'(mem_addr_q.size()), 32'd0);
    check("t2_valid", 32'(instr_valid_o), 32'd1);
    check("t2_head", pc_o, 32'h0);
    step();
    instr_ready_i = 1'b1;
    repeat (12) step();
    check_pop("t2_p0", 0, 32'h00, 32'h1000_0000, 1'b0);
    check_pop("t2_p1", 1, 32'h04, 32'h1000_0004, 1'b0);
    check_pop("t2_p2", 2, 32'h08, 32'h1000_0008, 1'b0);
    check_pop("t2_p3", 3, 32'h0C, 32'h1000_000C, 1'b0);
    check_pop("t2_p4", 4, 32'h10, 32'h1000_0010, 1'b0);

    // Redirect with two requests in flight on a 3-cycle memory
    lat = 3; instr_ready_i = 1'b1;
    do_reset();
    step(); step();
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    @(negedge clk);
    check("t3_req_redir", 32'(imem_bus.req), 32'd0);
    check("t3_inflight", 32'(mem_addr_q.size()), 32'd2);
    step();
    redirect_i = 1'b0;
    repeat (12) step();
    check_pop("t3_p0", 0, 32'h100, 32'h1000_0100, 1'b0);
    check_pop("t3_p1", 1, 32'h104, 32'h1000_0104, 1'b0);

    // Redirect coincident with rvalid and a pop
    lat = 1;
    do_reset();
    step(); step(); step();
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    pop_pc.delete(); pop_instr.delete(); pop_fault.delete();
    @(negedge clk);
    check("t4_valid_redir", 32'(instr_valid_o), 32'd1);
    check("t4_pc_redir", pc_o, 32'h4);
    step();
    redirect_i = 1'b0;
    @(negedge clk);
    check("t4_empty", 32'(instr_valid_o), 32'd0);
    check("t4_req", 32'(imem_bus.req), 32'd1);
    check("t4_addr", imem_bus.addr, 32'h200);
    repeat (6) step();
    check_pop("t4_p0", 0, 32'h200, 32'h1000_0200, 1'b0);
    check_pop("t4_p1", 1, 32'h204, 32'h1000_0204, 1'b0);

    // Back-to-back redirects with responses pending
    lat = 3;
    do_reset();
    step(); step();
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    pop_pc.delete(); pop_instr.delete(); pop_fault.delete();
    step();
    redirect_pc_i = 32'h300;
    step();
    redirect_i = 1'b0;
    @(negedge clk);
    check("t5_req", 32'(imem_bus.req), 32'd1);
    check("t5_addr", imem_bus.addr, 32'h300);
    repeat (12) step();
    check_pop("t5_p0", 0, 32'h300, 32'h1000_0300, 1'b0);
    check("t5_grants", 32'(grants.size() > 2), 32'd1);
    if (grants.size() > 2) check("t5_grant2", grants[2], 32'h300);

    // Misaligned redirect target
    lat = 1;
    do_reset();
    step(); step(); step();
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    pop_pc.delete(); pop_instr.delete(); pop_fault.delete();
    step();
    redirect_i = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    @(negedge clk);
    check("t6_req_halt0", 32'(imem_bus.req), 32'd0);
    step(); @(negedge clk);
    check("t6_fault_valid", 32'(instr_valid_o), 32'd1);
    check("t6_fault_flag", 32'(fault_w), 32'd1);
    repeat (5) step();
    @(negedge clk);
    check("t6_req_halt1", 32'(imem_bus.req), 32'd0);
    check("t6_single", 32'(instr_valid_o), 32'd0);
    check("t6_no_grant", 32'(grants.size()), 32'd3);
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    step();
    redirect_i = 1'b0;
    repeat (6) step();
    check_pop("t6_p0", 0, 32'h102, 32'h0000_0013, 1'b1);
    check_pop("t6_p1", 1, 32'h200, 32'h1000_0200, 1'b0);
`else
    @(negedge clk);
    check("t6_req", 32'(imem_bus.req), 32'd1);
    check("t6_addr", imem_bus.addr, 32'h100);
    repeat (6) step();
    check_pop("t6_p0", 0, 32'h100, 32'h1000_0100, 1'b0);
    check_pop("t6_p1", 1, 32'h104, 32'h1000_0104, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
